// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen : program-counter generator for the single-cycle RISC-V core.
//
// Holds the architectural PC and picks the next value every cycle from
// PC+4, a branch/jump redirect, the trap vector, or the saved exception PC
// (mret). Adds a post-reset boot hold, a debug halt/resume state, stall
// support and detection of misaligned redirect targets (which become traps).
//
// Parameters
//   XLEN          address width (32 or 64)
//   RESET_VECTOR  PC loaded at reset, 4-byte aligned
//   BOOT_DELAY    cycles spent in BOOT after reset release (1..15)
//
// Ports
//   clk                rising-edge clock
//   reset_n            asynchronous active-low reset
//   stall_i            hold PC; all other requests ignored in RUN
//   redirect_valid_i   branch/jump taken this cycle
//   redirect_target_i  branch/jump target
//   trap_req_i         exception/interrupt entry request
//   mtvec_i            trap vector base, bits [1:0] ignored
//   mret_i             return from trap
//   halt_req_i         debug halt request
//   resume_i           debug resume
//   pc_o               current PC
//   pc_plus4_o         pc_o + 4 (combinational, wraps)
//   pc_valid_o         high only in RUN
//   epc_o              saved exception PC
//   trap_taken_o       pulse in the cycle pc_o first shows the trap vector
//   misalign_o         pulse alongside trap_taken_o for misaligned redirects
//   halted_o           high in HALT
//   state_o            debug view of the FSM state (BOOT=0, RUN=1, HALT=2)
//
// Handshake note: there is no valid/ready pair here. Every request input is
// a level sampled at the rising edge; its effect is visible in pc_o right
// after that edge. Requests are only honoured in RUN, with a fixed priority
// stall > trap > misaligned redirect > mret > redirect > halt > PC+4.
// -----------------------------------------------------------------------------
module pc_gen #(
  parameter int          XLEN         = 32,
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter int          BOOT_DELAY   = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_req_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic            mret_i,
  input  logic            halt_req_i,
  input  logic            resume_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] epc_o,
  output logic            trap_taken_o,
  output logic            misalign_o,
  output logic            halted_o,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] RST_PC     = RESET_VECTOR[XLEN-1:0];
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(3);
  // Counter value on which BOOT hands over to RUN; reaching it after
  // BOOT_DELAY-1 increments gives exactly BOOT_DELAY edges in BOOT.
  localparam logic [3:0]      BOOT_LAST  = 4'(BOOT_DELAY - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [3:0]      boot_cnt_q, boot_cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            trap_taken_q, trap_taken_d;
  logic            misalign_q, misalign_d;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] pc_next_seq;
  logic [XLEN-1:0] trap_vec;
  logic            target_misaligned;

  // Natural XLEN-bit wrap: 2^XLEN-4 + 4 becomes 0 with no flag.
  assign pc_next_seq       = pc_q + PC_STEP;
  // Low two bits of mtvec are mode bits elsewhere; here they are forced to 0.
  assign trap_vec          = mtvec_i & ~ALIGN_MASK;
  assign target_misaligned = (redirect_target_i & ALIGN_MASK) != '0;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_BOOT;
      boot_cnt_q   <= 4'd0;
      pc_q         <= RST_PC;
      epc_q        <= '0;
      trap_taken_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      boot_cnt_q   <= boot_cnt_d;
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      trap_taken_q <= trap_taken_d;
      misalign_q   <= misalign_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-PC logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    pc_d         = pc_q;
    epc_d        = epc_q;
    trap_taken_d = 1'b0;
    misalign_d   = 1'b0;

    case (state_q)
      ST_BOOT: begin
        // PC holds and every request is ignored while booting.
        boot_cnt_d = boot_cnt_q + 4'd1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!stall_i) begin
          if (trap_req_i) begin
            epc_d        = pc_q;
            pc_d         = trap_vec;
            trap_taken_d = 1'b1;
          end else if (redirect_valid_i && target_misaligned) begin
            // A misaligned target is never fetched; it is turned into a trap
            // and the target itself is dropped.
            epc_d        = pc_q;
            pc_d         = trap_vec;
            trap_taken_d = 1'b1;
            misalign_d   = 1'b1;
          end else if (mret_i) begin
            pc_d = epc_q;
          end else if (redirect_valid_i) begin
            pc_d = redirect_target_i;
          end else if (halt_req_i) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_next_seq;
          end
        end
      end

      ST_HALT: begin
        // resume wins over a simultaneous halt request; PC is unchanged.
        if (resume_i) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pc_o         = pc_q;
  assign pc_plus4_o   = pc_next_seq;
  assign epc_o        = epc_q;
  assign pc_valid_o   = (state_q == ST_RUN);
  assign halted_o     = (state_q == ST_HALT);
  assign trap_taken_o = trap_taken_q;
  assign misalign_o   = misalign_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen : self-checking bench for pc_gen (XLEN=32, RESET_VECTOR=0x80,
// BOOT_DELAY=2). Directed vector table, an asynchronous-reset sequence, then
// randomized stimulus checked against a behavioural model.
// -----------------------------------------------------------------------------
module tb_pc_gen;

  localparam int          XLEN  = 32;
  localparam logic [31:0] RV    = 32'h0000_0080;
  localparam int          BDLY  = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        stall, redir, trap, mret, halt, resume;
  logic [31:0] tgt, mtvec;
  logic [31:0] pc, pc_plus4, epc;
  logic        valid, trap_taken, misalign, halted;
  logic [1:0]  state_dbg;

  pc_gen #(
    .XLEN        (XLEN),
    .RESET_VECTOR({32'h0, RV}),
    .BOOT_DELAY  (BDLY)
  ) dut (
    .clk              (clk),
    .reset_n          (rst_n),
    .stall_i          (stall),
    .redirect_valid_i (redir),
    .redirect_target_i(tgt),
    .trap_req_i       (trap),
    .mtvec_i          (mtvec),
    .mret_i           (mret),
    .halt_req_i       (halt),
    .resume_i         (resume),
    .pc_o             (pc),
    .pc_plus4_o       (pc_plus4),
    .pc_valid_o       (valid),
    .epc_o            (epc),
    .trap_taken_o     (trap_taken),
    .misalign_o       (misalign),
    .halted_o         (halted),
    .state_o          (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    stall = 0; redir = 0; tgt = 0; trap = 0; mtvec = 32'h1003;
    mret = 0; halt = 0; resume = 0;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        stall, redir, trap, mret, halt, resume;
    logic [31:0] tgt, mtvec;
    logic [31:0] e_pc, e_epc;
    logic        e_valid, e_trap, e_mis, e_halted;
  } vec_t;

  vec_t vecs[$];

  // Request field order: stall redir trap mret halt resume
  function automatic vec_t mk(input logic [5:0] req, input logic [31:0] t, input logic [31:0] mt,
                              input logic [31:0] e_pc, input logic [31:0] e_epc,
                              input logic [3:0] flags);  // valid trap mis halted
    vec_t v;
    {v.stall, v.redir, v.trap, v.mret, v.halt, v.resume} = req;
    v.tgt = t; v.mtvec = mt; v.e_pc = e_pc; v.e_epc = e_epc;
    {v.e_valid, v.e_trap, v.e_mis, v.e_halted} = flags;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural reference model (used for the randomized phase)
  // ---------------------------------------------------------------------------
  int          m_boot_left;
  bit          m_halted;
  logic [31:0] m_pc, m_epc;
  bit          m_trap, m_mis;

  task automatic model_reset();
    m_boot_left = BDLY; m_halted = 0; m_pc = RV; m_epc = 0; m_trap = 0; m_mis = 0;
  endtask

  // Applies the inputs seen at one rising edge.
  task automatic model_edge();
    m_trap = 0; m_mis = 0;
    if (m_boot_left > 0) begin
      m_boot_left = m_boot_left - 1;
    end else if (m_halted) begin
      if (resume) m_halted = 0;
    end else if (stall) begin
      // nothing moves
    end else if (trap || (redir && (tgt % 4 != 0))) begin
      m_epc  = m_pc;
      m_pc   = mtvec - (mtvec % 4);
      m_trap = 1;
      m_mis  = !trap;
    end else if (mret) begin
      m_pc = m_epc;
    end else if (redir) begin
      m_pc = tgt;
    end else if (halt) begin
      m_halted = 1;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_model(input string tag);
    exp_q.push_back(m_pc);
    check({tag, " pc"}, pc, exp_q.pop_front());
    check({tag, " pc_plus4"}, pc_plus4, m_pc + 32'd4);
    check({tag, " epc"}, epc, m_epc);
    check({tag, " valid"}, {31'b0, valid}, {31'b0, (m_boot_left == 0) && !m_halted});
    check({tag, " halted"}, {31'b0, halted}, {31'b0, m_halted});
    check({tag, " trap_taken"}, {31'b0, trap_taken}, {31'b0, m_trap});
    check({tag, " misalign"}, {31'b0, misalign}, {31'b0, m_mis});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " pc"}, pc, RV);
    check({tag, " epc"}, epc, 32'h0);
    check({tag, " valid"}, {31'b0, valid}, 32'h0);
    check({tag, " trap_taken"}, {31'b0, trap_taken}, 32'h0);
    check({tag, " misalign"}, {31'b0, misalign}, 32'h0);
    check({tag, " halted"}, {31'b0, halted}, 32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main test
  // ---------------------------------------------------------------------------
  initial begin
    idle_inputs();

    //                  req       tgt           mtvec         e_pc          e_epc         flags(v,t,m,h)
    vecs.push_back(mk(6'b000000, 32'h0,        32'h1003, 32'h80,       32'h0,    4'b0000)); // BOOT
    vecs.push_back(mk(6'b000000, 32'h0,        32'h1003, 32'h80,       32'h0,    4'b1000)); // first RUN
    vecs.push_back(mk(6'b000000, 32'h0,        32'h1003, 32'h84,       32'h0,    4'b1000));
    vecs.push_back(mk(6'b000000, 32'h0,        32'h1003, 32'h88,       32'h0,    4'b1000));
    vecs.push_back(mk(6'b010000, 32'h200,      32'h1003, 32'h200,      32'h0,    4'b1000)); // redirect
    vecs.push_back(mk(6'b100000, 32'h0,        32'h1003, 32'h200,      32'h0,    4'b1000)); // stall
    vecs.push_back(mk(6'b110000, 32'h300,      32'h1003, 32'h200,      32'h0,    4'b1000)); // stall+redir
    vecs.push_back(mk(6'b100000, 32'h0,        32'h1003, 32'h200,      32'h0,    4'b1000));
    vecs.push_back(mk(6'b000000, 32'h0,        32'h1003, 32'h204,      32'h0,    4'b1000));
    vecs.push_back(mk(6'b001000, 32'h0,        32'h1003, 32'h1000,     32'h204,  4'b1100)); // trap
    vecs.push_back(mk(6'b000000, 32'h0,        32'h1003, 32'h1004,     32'h204,  4'b1000));
    vecs.push_back(mk(6'b000100, 32'h0,        32'h1003, 32'h204,      32'h204,  4'b1000)); // mret
    vecs.push_back(mk(6'b010000, 32'h300,      32'h1003, 32'h300,      32'h204,  4'b1000));
    vecs.push_back(mk(6'b010000, 32'h402,      32'h1003, 32'h1000,     32'h300,  4'b1110)); // misalign
    vecs.push_back(mk(6'b011100, 32'h500,      32'h2001, 32'h2000,     32'h1000, 4'b1100)); // trap wins
    vecs.push_back(mk(6'b010000, 32'hFFFFFFFC, 32'h1003, 32'hFFFFFFFC, 32'h1000, 4'b1000));
    vecs.push_back(mk(6'b000010, 32'h0,        32'h1003, 32'hFFFFFFFC, 32'h1000, 4'b0001)); // halt
    vecs.push_back(mk(6'b001010, 32'h0,        32'h1003, 32'hFFFFFFFC, 32'h1000, 4'b0001)); // trap ignored
    vecs.push_back(mk(6'b010010, 32'h40,       32'h1003, 32'hFFFFFFFC, 32'h1000, 4'b0001));
    vecs.push_back(mk(6'b000100, 32'h0,        32'h1003, 32'hFFFFFFFC, 32'h1000, 4'b0001));
    vecs.push_back(mk(6'b000000, 32'h0,        32'h1003, 32'hFFFFFFFC, 32'h1000, 4'b0001));
    vecs.push_back(mk(6'b000011, 32'h0,        32'h1003, 32'hFFFFFFFC, 32'h1000, 4'b1000)); // resume+halt
    vecs.push_back(mk(6'b000000, 32'h0,        32'h1003, 32'h0,        32'h1000, 4'b1000)); // wrap

    // Reset, released away from the clock edge.
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset_hold");
    rst_n = 1;
    #1;
    check_reset_values("reset_release");

    // Directed table.
    for (int i = 0; i < vecs.size(); i++) begin
      stall = vecs[i].stall; redir = vecs[i].redir; tgt = vecs[i].tgt;
      trap = vecs[i].trap; mtvec = vecs[i].mtvec; mret = vecs[i].mret;
      halt = vecs[i].halt; resume = vecs[i].resume;
      step();
      check($sformatf("vec%0d pc", i), pc, vecs[i].e_pc);
      check($sformatf("vec%0d pc_plus4", i), pc_plus4, vecs[i].e_pc + 32'd4);
      check($sformatf("vec%0d epc", i), epc, vecs[i].e_epc);
      check($sformatf("vec%0d valid", i), {31'b0, valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("vec%0d trap_taken", i), {31'b0, trap_taken}, {31'b0, vecs[i].e_trap});
      check($sformatf("vec%0d misalign", i), {31'b0, misalign}, {31'b0, vecs[i].e_mis});
      check($sformatf("vec%0d halted", i), {31'b0, halted}, {31'b0, vecs[i].e_halted});
    end

    // Async reset mid-cycle in RUN while a trap pulse is showing.
    idle_inputs();
    trap  = 1;
    step();
    check("pre_reset trap_taken", {31'b0, trap_taken}, 32'h1);
    check("pre_reset pc", pc, 32'h1000);
    idle_inputs();
    #2;
    rst_n = 0;
    #1;
    check_reset_values("async_reset");
    #1;
    rst_n = 1;

    // Boot again and then randomized traffic against the model.
    model_reset();
    check_model("rand_start");
    for (int i = 0; i < 600; i++) begin
      stall  = ($urandom_range(0, 7) == 0);
      redir  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0:       tgt = $urandom;                          // often misaligned
        1:       tgt = 32'hFFFFFFFC;                      // exercises wrap
        default: tgt = $urandom & 32'hFFFF_FFFC;
      endcase
      trap   = ($urandom_range(0, 15) == 0);
      mtvec  = $urandom;
      mret   = ($urandom_range(0, 7) == 0);
      halt   = ($urandom_range(0, 15) == 0);
      resume = ($urandom_range(0, 3) == 0);
      step();
      model_edge();
      check_model($sformatf("rand%0d", i));
      if ($urandom_range(0, 149) == 0) begin
        #2;
        rst_n = 0;
        #1;
        check_reset_values($sformatf("rand%0d reset", i));
        model_reset();
        #1;
        rst_n = 1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
